// File: rtl/ads412x_cfg_seq.sv
// ads412x_cfg_seq
//   Power-up and runtime configuration sequencer for the ADS412x ADC.
//   After reset it pulses adc_reset, waits for the ADC to settle, then writes
//   the init register table over the 3-wire SPI. Afterwards single register
//   writes are accepted from a requester through a req/ack handshake.
//
// Ports
//   clk_in       system clock
//   rst_n        asynchronous active-low reset
//   cfg_restart  pulse while idle: rerun reset pulse + init table
//   wr_req       write request, held until wr_ack
//   wr_addr      register address (8 bits)
//   wr_data      register data (8 bits)
//   wr_ack       one-cycle pulse, request accepted
//   busy         high whenever the sequencer is not idle
//   init_done    high once the init table has been written
//   adc_reset    ADC hardware reset, active high
//   adc_sen      SPI enable, active low
//   adc_sclk     SPI clock, idles low
//   adc_sdata    SPI data, MSB first
module ads412x_cfg_seq #(
  parameter int SCLK_DIV  = 5,
  parameter int RST_PULSE = 10,
  parameter int RST_WAIT  = 100,
  parameter int NUM_INIT  = 4,
  parameter logic [NUM_INIT*16-1:0] INIT_TABLE = 64'h4200_2500_3D00_3F00
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       cfg_restart,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       busy,
  output logic       init_done,
  output logic       adc_reset,
  output logic       adc_sen,
  output logic       adc_sclk,
  output logic       adc_sdata
);

  localparam int TMAX0 = (RST_PULSE > RST_WAIT) ? RST_PULSE : RST_WAIT;
  localparam int TMAX  = (TMAX0 > SCLK_DIV) ? TMAX0 : SCLK_DIV;
  localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int IW    = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;

  localparam logic [TW-1:0] PULSE_LAST = TW'(RST_PULSE - 1);
  localparam logic [TW-1:0] WAIT_LAST  = TW'(RST_WAIT - 1);
  localparam logic [TW-1:0] DIV_LAST   = TW'(SCLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_INIT - 1);

  typedef enum logic [2:0] {
    S_RST_PULSE, S_RST_WAIT, S_LOAD, S_SETUP, S_SHIFT, S_HOLD, S_GAP, S_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [4:0]    hcnt_q, hcnt_d;     // SCLK half-period index within a frame
  logic [IW-1:0] idx_q, idx_d;
  logic          init_mode_q, init_mode_d;
  logic [15:0]   shreg_q, shreg_d;
  logic [15:0]   wbuf_q, wbuf_d;
  logic          init_done_q, init_done_d;
  logic          adc_reset_q, adc_reset_d;
  logic          sen_q, sen_d;
  logic          sclk_q, sclk_d;
  logic          sdata_q, sdata_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;

  function automatic logic [15:0] init_word(input logic [IW-1:0] idx);
    init_word = '0;
    for (int k = 0; k < NUM_INIT; k++) begin
      if (idx == IW'(k)) init_word = INIT_TABLE[16*(NUM_INIT-1-k) +: 16];
    end
  endfunction

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RST_PULSE;
      t_q         <= '0;
      hcnt_q      <= '0;
      idx_q       <= '0;
      init_mode_q <= 1'b1;
      shreg_q     <= '0;
      wbuf_q      <= '0;
      init_done_q <= 1'b0;
      adc_reset_q <= 1'b0;
      sen_q       <= 1'b1;
      sclk_q      <= 1'b0;
      sdata_q     <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      hcnt_q      <= hcnt_d;
      idx_q       <= idx_d;
      init_mode_q <= init_mode_d;
      shreg_q     <= shreg_d;
      wbuf_q      <= wbuf_d;
      init_done_q <= init_done_d;
      adc_reset_q <= adc_reset_d;
      sen_q       <= sen_d;
      sclk_q      <= sclk_d;
      sdata_q     <= sdata_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    t_d         = t_q + TW'(1);
    hcnt_d      = hcnt_q;
    idx_d       = idx_q;
    init_mode_d = init_mode_q;
    shreg_d     = shreg_q;
    wbuf_d      = wbuf_q;
    init_done_d = init_done_q;
    adc_reset_d = 1'b0;
    sen_d       = 1'b1;
    sclk_d      = 1'b0;
    ack_d       = 1'b0;
    case (state_q)
      S_RST_PULSE: begin
        adc_reset_d = 1'b1;
        if (t_q == PULSE_LAST) begin
          state_d = S_RST_WAIT;
          t_d     = '0;
        end
      end
      S_RST_WAIT: begin
        idx_d = '0;
        if (t_q == WAIT_LAST) begin
          state_d     = S_LOAD;
          t_d         = '0;
          init_mode_d = 1'b1;
        end
      end
      S_LOAD: begin
        sen_d   = 1'b0;
        shreg_d = init_mode_q ? init_word(idx_q) : wbuf_q;
        state_d = S_SETUP;
        t_d     = '0;
      end
      S_SETUP: begin
        sen_d = 1'b0;
        if (t_q == DIV_LAST) begin
          state_d = S_SHIFT;
          t_d     = '0;
          hcnt_d  = '0;
        end
      end
      S_SHIFT: begin
        sen_d  = 1'b0;
        // Even half-periods are SCLK high, odd are low.
        sclk_d = ~hcnt_q[0];
        // Shift on the cycle SCLK falls so data is stable across every rise.
        if (hcnt_q[0] && t_q == '0) shreg_d = {shreg_q[14:0], 1'b0};
        if (t_q == DIV_LAST) begin
          t_d    = '0;
          hcnt_d = hcnt_q + 5'd1;
          if (hcnt_q == 5'd31) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        sen_d = 1'b0;
        if (t_q == DIV_LAST) begin
          state_d = S_GAP;
          t_d     = '0;
        end
      end
      S_GAP: begin
        if (t_q == DIV_LAST) begin
          t_d = '0;
          if (init_mode_q && idx_q != IDX_LAST) begin
            idx_d   = idx_q + IW'(1);
            state_d = S_LOAD;
          end else begin
            if (init_mode_q) init_done_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        t_d = '0;
        // Restart has priority; a held request is served after the re-init.
        if (cfg_restart) begin
          state_d     = S_RST_PULSE;
          init_done_d = 1'b0;
        end else if (wr_req) begin
          wbuf_d      = {wr_addr, wr_data};
          ack_d       = 1'b1;
          init_mode_d = 1'b0;
          state_d     = S_LOAD;
        end
      end
      default: begin
        state_d = S_RST_PULSE;
        t_d     = '0;
      end
    endcase
    sdata_d = shreg_d[15];
    busy_d  = (state_d != S_IDLE);
  end

  assign wr_ack    = ack_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign adc_reset = adc_reset_q;
  assign adc_sen   = sen_q;
  assign adc_sclk  = sclk_q;
  assign adc_sdata = sdata_q;

endmodule

// File: tb/tb_ads412x_cfg_seq.sv
// Testbench for ads412x_cfg_seq: directed scenarios covering reset timing,
// init table transmission, user writes, restart arbitration and async abort.
module tb_ads412x_cfg_seq;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       cfg_restart;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack, busy, init_done, adc_reset, adc_sen, adc_sclk, adc_sdata;

  int errors = 0;
  int checks = 0;

  ads412x_cfg_seq dut (
    .clk_in(clk_in), .rst_n(rst_n), .cfg_restart(cfg_restart),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .busy(busy), .init_done(init_done),
    .adc_reset(adc_reset), .adc_sen(adc_sen), .adc_sclk(adc_sclk),
    .adc_sdata(adc_sdata)
  );

  always #5 clk_in = ~clk_in;

  // SPI monitor: samples on the falling clock edge, captures sdata on each
  // SCLK rise and logs one word per frame when SEN returns high.
  logic [15:0] frames[$];
  int          rise_q[$];
  logic [15:0] sh = '0;
  int          rises = 0;
  int          hi_run = 0;
  int          gaps = 0;
  int          short_gaps = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_sen = 1'b1;
  logic        seen = 1'b0;

  always @(negedge clk_in) begin
    if (!rst_n) begin
      prev_sclk <= 1'b0;
      prev_sen  <= 1'b1;
      rises     <= 0;
      sh        <= '0;
      hi_run    <= 0;
      seen      <= 1'b0;
    end else begin
      prev_sclk <= adc_sclk;
      prev_sen  <= adc_sen;
      if (adc_sclk && !prev_sclk) begin
        sh    <= {sh[14:0], adc_sdata};
        rises <= rises + 1;
      end
      if (adc_sen && !prev_sen) begin
        frames.push_back(sh);
        rise_q.push_back(rises);
        rises <= 0;
        seen  <= 1'b1;
      end
      hi_run <= adc_sen ? hi_run + 1 : 0;
      if (!adc_sen && prev_sen && seen) begin
        gaps <= gaps + 1;
        if (hi_run < 5) short_gaps <= short_gaps + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Measures adc_reset high time and the quiet time before SEN first falls.
  task automatic measure_rst(output int hi, output int wt);
    int n;
    n = 0;
    while (!adc_reset && n < 50) begin @(negedge clk_in); n++; end
    hi = 0;
    while (adc_reset && hi < 50) begin hi++; @(negedge clk_in); end
    wt = 0;
    while (adc_sen && !adc_reset && wt < 300) begin wt++; @(negedge clk_in); end
  endtask

  task automatic wait_done(input string tag);
    int   n;
    logic pb;
    n  = 0;
    pb = 1'b0;
    while (!init_done && n < 3000) begin pb = busy; @(negedge clk_in); n++; end
    chk({tag, "_done"}, init_done, 1);
    chk({tag, "_busy_fall"}, busy, 0);
    chk({tag, "_busy_before"}, pb, 1);
  endtask

  task automatic chk_frames(input string tag, input logic [15:0] exp[$]);
    chk({tag, "_nframes"}, frames.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < frames.size()) begin
        chk($sformatf("%s_frame%0d", tag, i), frames[i], exp[i]);
        chk($sformatf("%s_rises%0d", tag, i), rise_q[i], 16);
      end
    end
  endtask

  initial begin
    int          hi, wt, n, acks;
    logic        pd, pd2;
    logic [15:0] init_exp[$];
    logic [15:0] exp5[$];
    init_exp = '{16'h4200, 16'h2500, 16'h3D00, 16'h3F00};

    rst_n = 1'b0; cfg_restart = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk_in);
    chk("reset_outs", {adc_reset, adc_sen, adc_sclk, adc_sdata, wr_ack, busy, init_done}, 7'b0100010);
    rst_n = 1'b1;

    // Power-up: pulse width, settle time, init table
    measure_rst(hi, wt);
    chk("rst_pulse_len", hi, 10);
    chk("rst_wait_len", wt, 100);
    wait_done("init");
    chk_frames("init", init_exp);
    chk("sen_gap_short", short_gaps, 0);
    chk("sen_gap_seen", gaps >= 3, 1);

    // Single user write from idle
    frames.delete(); rise_q.delete();
    wr_addr = 8'h42; wr_data = 8'hA5; wr_req = 1'b1;
    n = 0; acks = 0;
    @(negedge clk_in);
    while (busy && n < 400) begin
      acks += int'(wr_ack);
      if (wr_ack) wr_req = 1'b0;
      n++;
      @(negedge clk_in);
    end
    wr_req = 1'b0;
    chk("wr_busy_len", n, 176);
    chk("wr_ack_cnt", acks, 1);
    chk("wr_done_kept", init_done, 1);
    exp5 = '{16'h42A5};
    chk_frames("wr", exp5);

    // Restart and request in the same idle cycle
    frames.delete(); rise_q.delete();
    @(negedge clk_in);
    cfg_restart = 1'b1; wr_req = 1'b1; wr_addr = 8'h3C; wr_data = 8'h5A;
    @(negedge clk_in);
    cfg_restart = 1'b0;
    chk("rs_no_ack", wr_ack, 0);
    chk("rs_done_clr", init_done, 0);
    chk("rs_busy", busy, 1);
    measure_rst(hi, wt);
    chk("rs_pulse_len", hi, 10);
    chk("rs_wait_len", wt, 100);
    n = 0; pd = 1'b0; pd2 = 1'b0;
    while (!wr_ack && n < 4000) begin pd2 = pd; pd = init_done; @(negedge clk_in); n++; end
    chk("rs_acked", wr_ack, 1);
    chk("rs_ack_first_idle", {pd2, pd}, 2'b01);
    chk("rs_ack_done", init_done, 1);
    wr_req = 1'b0;
    acks = 0; n = 0;
    @(negedge clk_in);
    while (busy && n < 400) begin acks += int'(wr_ack); n++; @(negedge clk_in); end
    chk("rs_extra_ack", acks, 0);
    exp5 = '{16'h4200, 16'h2500, 16'h3D00, 16'h3F00, 16'h3C5A};
    chk_frames("rs", exp5);

    // Asynchronous reset in the middle of a frame
    @(negedge clk_in);
    wr_addr = 8'h81; wr_data = 8'h7E; wr_req = 1'b1;
    n = 0;
    while (rises != 8 && n < 300) begin
      @(negedge clk_in);
      if (wr_ack) wr_req = 1'b0;
      n++;
    end
    wr_req = 1'b0;
    #1;
    chk("pre_abort", {adc_sen, adc_sclk, adc_sdata}, 3'b011);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {adc_reset, adc_sen, adc_sclk, adc_sdata, wr_ack, busy, init_done}, 7'b0100010);
    repeat (3) @(negedge clk_in);
    frames.delete(); rise_q.delete();
    rst_n = 1'b1;
    measure_rst(hi, wt);
    chk("ab_pulse_len", hi, 10);
    chk("ab_wait_len", wt, 100);
    wait_done("ab");
    chk_frames("ab", init_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
